// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared widths and stage record for the multiply pipeline (MUL_HIGH_EN adds MULH state)
package params_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int REGISTER_WIDTH  = 5;
  localparam int MUL_CHUNK_WIDTH = 8;
  localparam int MUL_STAGES      = 5;

`ifdef MUL_HIGH_EN
  // Full product is kept so the upper word is available for MULH.
  localparam int ACC_WIDTH = 2 * DATA_WIDTH;
`else
  localparam int ACC_WIDTH = DATA_WIDTH;
`endif

  localparam logic [2:0] FUNCT3_MULH = 3'b001;

  // One in-flight multiply: operands travel with the instruction.
  typedef struct packed {
    logic                      valid;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     rs1;
    logic [DATA_WIDTH-1:0]     rs2;
    logic [ACC_WIDTH-1:0]      acc;
`ifdef MUL_HIGH_EN
    logic                      negate;
    logic                      is_high;
`endif
  } mul_stage_t;

endpackage

// File: rtl/mul_pp_step.sv
// rtl/mul_pp_step.sv - one multiplier-chunk partial-product accumulate step
module mul_pp_step #(
  parameter int STEP        = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int ACC_WIDTH   = 32
) (
  input  logic [DATA_WIDTH-1:0]  rs1,
  input  logic [CHUNK_WIDTH-1:0] chunk,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  output logic [ACC_WIDTH-1:0]   acc_out
);

  logic [ACC_WIDTH-1:0] mcand;
  logic [ACC_WIDTH-1:0] mplier;
  logic [ACC_WIDTH-1:0] partial;

  // Zero-extend both factors so the product is computed at accumulator width.
  assign mcand   = ACC_WIDTH'(rs1);
  assign mplier  = ACC_WIDTH'(chunk);
  assign partial = (mcand * mplier) << (STEP * CHUNK_WIDTH);
  assign acc_out = acc_in + partial;

endmodule

// File: rtl/mul_pipeline.sv
// rtl/mul_pipeline.sv - five-stage pipelined multiplier, MUL by default, MULH when MUL_HIGH_EN is defined
module mul_pipeline
  import params_pkg::*;
#(
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int CHUNK_WIDTH    = params_pkg::MUL_CHUNK_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
  input  logic [2:0]                funct3_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      ex1_valid_o,
  output logic                      ex2_valid_o,
  output logic                      ex3_valid_o,
  output logic                      ex4_valid_o,
  output logic                      ex5_valid_o,
  output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex5_wr_reg_o,
  output logic [DATA_WIDTH-1:0]     ex5_result_o,
  output logic                      busy_o
);

  // ex1..ex4 carry full operand records; ex5 only needs the final word.
  localparam int NSTEP = MUL_STAGES - 1;

  if (DATA_WIDTH != params_pkg::DATA_WIDTH || REGISTER_WIDTH != params_pkg::REGISTER_WIDTH ||
      CHUNK_WIDTH != params_pkg::MUL_CHUNK_WIDTH || DATA_WIDTH / CHUNK_WIDTH != NSTEP) begin : g_bad_cfg
    $error("mul_pipeline: parameters must match params_pkg and give four chunks");
  end

  mul_stage_t                stg [1:NSTEP];
  mul_stage_t                ex1_load;
  logic [ACC_WIDTH-1:0]      acc_next [2:MUL_STAGES];
  logic [DATA_WIDTH-1:0]     final_result;
  logic                      ex5_valid_q;
  logic [REGISTER_WIDTH-1:0] ex5_wr_reg_q;
  logic [DATA_WIDTH-1:0]     ex5_result_q;

`ifndef MUL_HIGH_EN
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i;
`endif

  // Build the ex1 record; MULH stores magnitudes plus a sign flag.
  always_comb begin
    ex1_load        = '0;
    ex1_load.valid  = valid_i;
    ex1_load.wr_reg = wr_reg_i;
    ex1_load.rs1    = rs1_data_i;
    ex1_load.rs2    = rs2_data_i;
`ifdef MUL_HIGH_EN
    ex1_load.is_high = (funct3_i == FUNCT3_MULH);
    if (ex1_load.is_high) begin
      ex1_load.rs1    = rs1_data_i[DATA_WIDTH-1] ? -rs1_data_i : rs1_data_i;
      ex1_load.rs2    = rs2_data_i[DATA_WIDTH-1] ? -rs2_data_i : rs2_data_i;
      ex1_load.negate = rs1_data_i[DATA_WIDTH-1] ^ rs2_data_i[DATA_WIDTH-1];
    end
`endif
  end

  for (genvar k = 1; k <= NSTEP; k++) begin : g_step
    mul_pp_step #(
      .STEP        (k - 1),
      .DATA_WIDTH  (DATA_WIDTH),
      .CHUNK_WIDTH (CHUNK_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
    ) u_step (
      .rs1     (stg[k].rs1),
      .chunk   (stg[k].rs2[(k-1)*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .acc_in  (stg[k].acc),
      .acc_out (acc_next[k+1])
    );
  end

  // Resolve sign and word select on the way into ex5 so the result leaves a flop.
  always_comb begin
    final_result = acc_next[MUL_STAGES][DATA_WIDTH-1:0];
`ifdef MUL_HIGH_EN
    begin
      logic [ACC_WIDTH-1:0] signed_sum;
      signed_sum = stg[NSTEP].negate ? -acc_next[MUL_STAGES] : acc_next[MUL_STAGES];
      final_result = stg[NSTEP].is_high ? signed_sum[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : signed_sum[DATA_WIDTH-1:0];
    end
`endif
  end

  // Pipeline registers: reset, then flush over stall, then advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 1; k <= NSTEP; k++) stg[k] <= '0;
      ex5_valid_q  <= 1'b0;
      ex5_wr_reg_q <= '0;
      ex5_result_q <= '0;
    end else if (flush_i) begin
      for (int k = 1; k <= NSTEP; k++) stg[k].valid <= 1'b0;
      ex5_valid_q <= 1'b0;
    end else if (!stall_i) begin
      stg[1] <= ex1_load;
      for (int k = 2; k <= NSTEP; k++) begin
        stg[k]     <= stg[k-1];
        stg[k].acc <= acc_next[k];
      end
      ex5_valid_q  <= stg[NSTEP].valid;
      ex5_wr_reg_q <= stg[NSTEP].wr_reg;
      ex5_result_q <= final_result;
    end
  end

  assign ex1_valid_o  = stg[1].valid;
  assign ex2_valid_o  = stg[2].valid;
  assign ex3_valid_o  = stg[3].valid;
  assign ex4_valid_o  = stg[4].valid;
  assign ex5_valid_o  = ex5_valid_q;
  assign ex1_wr_reg_o = stg[1].wr_reg;
  assign ex2_wr_reg_o = stg[2].wr_reg;
  assign ex3_wr_reg_o = stg[3].wr_reg;
  assign ex4_wr_reg_o = stg[4].wr_reg;
  assign ex5_wr_reg_o = ex5_wr_reg_q;
  assign ex5_result_o = ex5_result_q;
  assign busy_o       = stg[1].valid | stg[2].valid | stg[3].valid | stg[4].valid | ex5_valid_q;

endmodule

// File: doc/mul_pipeline.md
# mul_pipeline

Five-stage pipelined integer multiplier directly downstream of the decode stage; it consumes multiply instructions issued on decode's multiply-valid output and produces a write-back result from its last stage. Per-stage valid and destination-register outputs feed decode's hazard and bypass logic, and the stage-5 result is decode's multiply bypass source. Computation is four 32×8 partial-product accumulation steps, one per stage transition.

## Interface
Parameters:
- DATA_WIDTH, params_pkg::DATA_WIDTH (32): operand/result width.
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5): register index width.
- CHUNK_WIDTH, params_pkg::MUL_CHUNK_WIDTH (8): multiplier bits consumed per step; DATA_WIDTH/CHUNK_WIDTH must equal 4.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- valid_i  input  1  multiply issued this cycle (decode multiply-valid).
- rs1_data_i  input  DATA_WIDTH  multiplicand, post-bypass.
- rs2_data_i  input  DATA_WIDTH  multiplier, post-bypass.
- wr_reg_i  input  REGISTER_WIDTH  destination register.
- funct3_i  input  3  instruction funct3 (used only with MUL_HIGH_EN).
- stall_i  input  1  freeze all stages.
- flush_i  input  1  kill all in-flight multiplies.
- ex1_valid_o … ex5_valid_o  output  1 each  stage k holds a live multiply.
- ex1_wr_reg_o … ex5_wr_reg_o  output  REGISTER_WIDTH each  stage k destination.
- ex5_result_o  output  DATA_WIDTH  final product; meaningful only while ex5_valid_o.
- busy_o  output  1  OR of all stage valids.

## Operation
- Acceptance: valid_i & ~stall_i & ~flush_i loads ex1 with operands, wr_reg_i, accumulator = 0. Otherwise ex1 becomes invalid on an advancing cycle.
- Advance (~stall_i): stage k+1 ← stage k for k=1..4; on transition k→k+1 accumulator += rs1 × rs2[CHUNK_WIDTH·(k−1) +: CHUNK_WIDTH] << CHUNK_WIDTH·(k−1). Operands travel with the instruction. Invalid stages advance as bubbles; datapath of bubbles is don't-care but valids are exact.
- ex5_result_o = accumulator[DATA_WIDTH-1:0] (low-word MUL, sign-agnostic).
- stall_i: every stage register, including ex5, holds; valid_i ignored (decode must hold the instruction).
- flush_i: all valids cleared next edge; has priority over stall_i and valid_i. Datapath need not clear.
- wr_reg == 0 passes through unchanged; decode filters x0.
- Reset: all ex*_valid_o = 0, all ex*_wr_reg_o = 0, ex5_result_o = 0, busy_o = 0. Reset mid-operation discards in-flight work.

## Timing
- Latency 5: accepted at edge t, appears in ex1 after t, in ex5 after t+4 edges, i.e. ex5_valid_o high in cycle t+5 with result.
- Throughput one per cycle; back-to-back issue fully pipelined.
- Each stall cycle adds one cycle of latency to every in-flight op; ordering preserved.
- ex5 entry leaves after one non-stalled cycle; write-back captures it that cycle.
- All outputs registered; no combinational input-to-output path.

## Configuration
- MUL_HIGH_EN defined: funct3_i = 3'b001 selects MULH (signed×signed, upper word). ex1 stores operand magnitudes and a negate flag (sign(rs1) XOR sign(rs2)); accumulator widens to 2·DATA_WIDTH; ex5 applies two's-complement negation to the 64-bit sum when flagged and drives bits [63:32]. For funct3 000, low word unchanged (negation is consistent mod 2^32).
- Undefined: funct3_i ignored, 32-bit accumulator, no sign/high-select state.

## Structure
- params_pkg: MUL_CHUNK_WIDTH, MUL_STAGES (5), mul_stage_t struct {valid, wr_reg, rs1, rs2, acc, and under MUL_HIGH_EN negate, is_high}.
- Sub-module mul_pp_step: combinational one-chunk multiply-accumulate, parameterized by step index, instantiated four times between stage registers.

## Test plan
- Issue 5×7, rd=3 at cycle 0 → cycle 5: ex5_valid_o=1, ex5_wr_reg_o=3, ex5_result_o=35; ex1..ex4 valids pulse one cycle each in cycles 1..4.
- 0xFFFFFFFF×0xFFFFFFFF → 0x00000001; 0x12345678×0x10 → 0x23456780.
- Three back-to-back issues (2×3, 4×5, 6×7) → results 6, 20, 42 in consecutive cycles 5,6,7.
- Issue at cycle 0, stall_i high cycles 2–3 → result in cycle 7, valids frozen during stall.
- Two ops in flight, flush_i with stall_i high → all valids 0 next cycle, busy_o=0; reset mid-flight likewise.
- MUL_HIGH_EN: MULH −2×3 → 0xFFFFFFFF; MULH 0x80000000×0x80000000 → 0x40000000; MUL −2×3 → 0xFFFFFFFA.
